// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller with leading-zero blanking
// Staged values reach the display only at frame boundaries, so a frame never mixes two values.
module seg7_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int DIV      = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  output logic              ready,
  output logic [3:0]        num,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int PC_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(NDIG);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  logic [PC_W-1:0]   r_pc;
  logic [IDX_W-1:0]  r_idx;
  logic [4*NDIG-1:0] r_active;
  logic [4*NDIG-1:0] r_staged;
  logic              r_pending;
  logic              r_frame_done;

  logic              w_tick;
  logic              w_wrap;
  logic [3:0]        w_num;
  logic [NDIG-1:0]   w_sel;
  logic [IDX_W-1:0]  w_msd;

  assign w_tick = (r_pc == PC_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= '0;
      r_idx        <= '0;
      r_active     <= '0;
      r_staged     <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_pc         <= w_tick ? '0 : r_pc + PC_W'(1);
      r_frame_done <= w_wrap;
      if (w_tick) begin
        r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
      end
      // Commit reads the old staged value even when a load lands in the same cycle.
      if (w_wrap && r_pending) begin
        r_active <= r_staged;
      end
      if (load) begin
        r_staged <= value;
      end
      if (load) begin
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Digit mux, one-hot select and most-significant nonzero digit in one pass.
  always_comb begin
    w_num = 4'd0;
    w_sel = '0;
    w_msd = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (r_active[4*k +: 4] != 4'd0) begin
        w_msd = IDX_W'(k);
      end
      if (r_idx == IDX_W'(k)) begin
        w_num    = r_active[4*k +: 4];
        w_sel[k] = 1'b1;
      end
    end
  end

  assign num        = w_num;
  assign an         = ((BLANK_LZ != 0) && (r_idx > w_msd)) ? '0 : w_sel;
  assign ready      = !r_pending;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl
// Three instances: NDIG=4/DIV=4 unblanked (a) and blanked (b), NDIG=2/DIV=1 blanked (c).
module tb_seg7_scan_ctrl;

  localparam int NCYC = 112;

  typedef struct {
    int         n;
    logic [3:0] num;
    logic [7:0] an;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_a, load_b, load_c;
  logic [15:0] value_a, value_b;
  logic [7:0]  value_c;
  logic        ready_a, ready_b, ready_c;
  logic [3:0]  num_a, num_b, num_c;
  logic [3:0]  an_a, an_b;
  logic [1:0]  an_c;
  logic        fd_a, fd_b, fd_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int   n;
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] a_fr [7] = '{32'h0000, 32'h1234, 32'h5678, 32'h1111, 32'h2222, 32'h2222, 32'h3333};
  logic [31:0] b_fr [7] = '{32'h0000, 32'h0042, 32'h0000, 32'h00A0, 32'h00A0, 32'h00A0, 32'h00A0};

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NDIG(4), .DIV(4), .BLANK_LZ(0)) dut_a (
    .clk(clk), .rst(rst), .load(load_a), .value(value_a),
    .ready(ready_a), .num(num_a), .an(an_a), .frame_done(fd_a)
  );
  seg7_scan_ctrl #(.NDIG(4), .DIV(4), .BLANK_LZ(1)) dut_b (
    .clk(clk), .rst(rst), .load(load_b), .value(value_b),
    .ready(ready_b), .num(num_b), .an(an_b), .frame_done(fd_b)
  );
  seg7_scan_ctrl #(.NDIG(2), .DIV(1), .BLANK_LZ(1)) dut_c (
    .clk(clk), .rst(rst), .load(load_c), .value(value_c),
    .ready(ready_c), .num(num_c), .an(an_c), .frame_done(fd_c)
  );

  task automatic push_frame(input int dut, input int n0, input logic [31:0] v,
                            input int ndig, input int div, input bit blank);
    int   msd;
    exp_t e;
    msd = 0;
    for (int k = 0; k < ndig; k++) begin
      if (((v >> (4*k)) & 32'hF) != 0) msd = k;
    end
    for (int d = 0; d < ndig; d++) begin
      for (int c = 0; c < div; c++) begin
        e.n   = n0 + d*div + c;
        e.num = 4'((v >> (4*d)) & 32'hF);
        e.an  = (blank && d > msd) ? 8'h00 : 8'(1 << d);
        e.fd  = (n0 > 0) && (d == 0) && (c == 0);
        case (dut)
          0: q_a.push_back(e);
          1: q_b.push_back(e);
          default: q_c.push_back(e);
        endcase
      end
    end
  endtask

  task automatic chk(input string tag, input exp_t e, input logic [3:0] num,
                     input logic [7:0] an, input logic fd);
    vectors += 3;
    assert (num === e.num) else begin
      miscompares++;
      $error("FAIL %s num n=%0d: observed %0d expected %0d", tag, e.n, num, e.num);
    end
    assert (an === e.an) else begin
      miscompares++;
      $error("FAIL %s an n=%0d: observed %b expected %b", tag, e.n, an, e.an);
    end
    assert (fd === e.fd) else begin
      miscompares++;
      $error("FAIL %s frame_done n=%0d: observed %b expected %b", tag, e.n, fd, e.fd);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s n=%0d: observed %b expected %b", tag, n, got, exp);
    end
  endtask

  task automatic check_now();
    exp_t e;
    if (q_a.size() > 0 && q_a[0].n == n) begin
      e = q_a.pop_front();
      chk("a", e, num_a, {4'h0, an_a}, fd_a);
    end
    if (q_b.size() > 0 && q_b[0].n == n) begin
      e = q_b.pop_front();
      chk("b", e, num_b, {4'h0, an_b}, fd_b);
    end
    if (q_c.size() > 0 && q_c[0].n == n) begin
      e = q_c.pop_front();
      chk("c", e, num_c, {6'h0, an_c}, fd_c);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    n++;
    check_now();
  endtask

  initial begin
    rst = 1'b1;
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    value_a = '0; value_b = '0; value_c = '0;
    n = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Dirty dut_a: 9999 displayed, 7777 pending, then reset mid-frame.
    load_a = 1'b1; value_a = 16'h9999;
    @(posedge clk); #1 load_a = 1'b0;
    repeat (19) @(posedge clk);
    #1 load_a = 1'b1; value_a = 16'h7777;
    @(posedge clk); #1 load_a = 1'b0;
    vectors++;
    assert (num_a === 4'd9) else begin
      miscompares++;
      $error("FAIL pre_rst_num: observed %0d expected 9", num_a);
    end
    chk_bit("pre_rst_ready", ready_a, 1'b0);
    #2 rst = 1'b1;
    #1;
    vectors++;
    assert (num_a === 4'd0 && an_a === 4'b0001) else begin
      miscompares++;
      $error("FAIL async_rst num/an: observed %0d/%b expected 0/0001", num_a, an_a);
    end
    chk_bit("async_rst_ready", ready_a, 1'b1);
    chk_bit("async_rst_fd", fd_a, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    n = 0;
    push_frame(0, 0, a_fr[0], 4, 4, 1'b0);
    push_frame(1, 0, b_fr[0], 4, 4, 1'b1);
    push_frame(2, 0, 32'h00, 2, 1, 1'b1);
    check_now();
    chk_bit("rst_ready_a", ready_a, 1'b1);
    chk_bit("rst_ready_b", ready_b, 1'b1);
    chk_bit("rst_ready_c", ready_c, 1'b1);

    for (int i = 0; i < NCYC - 1; i++) begin
      case (n)
        2:  begin load_a = 1'b1; value_a = 16'h1234; load_b = 1'b1; value_b = 16'h0042; end
        5:  begin load_c = 1'b1; value_c = 8'h12; end
        6:  begin load_c = 1'b1; value_c = 8'h34; end
        20: begin load_b = 1'b1; value_b = 16'h0000; end
        21: begin load_a = 1'b1; value_a = 16'h5678; end
        36: begin load_b = 1'b1; value_b = 16'h00A0; end
        40: begin load_a = 1'b1; value_a = 16'h1111; end
        47: begin load_a = 1'b1; value_a = 16'h2222; end
        79: begin load_a = 1'b1; value_a = 16'h3333; end
        default: ;
      endcase
      case (n)
        2:  chk_bit("ready_a", ready_a, 1'b1);
        3:  chk_bit("ready_a", ready_a, 1'b0);
        7:  chk_bit("ready_c", ready_c, 1'b0);
        8:  chk_bit("ready_c", ready_c, 1'b1);
        16: chk_bit("ready_a", ready_a, 1'b1);
        21: chk_bit("ready_b", ready_b, 1'b0);
        22: chk_bit("ready_a", ready_a, 1'b0);
        31: chk_bit("ready_a", ready_a, 1'b0);
        32: chk_bit("ready_a", ready_a, 1'b1);
        37: chk_bit("ready_b", ready_b, 1'b0);
        41: chk_bit("ready_a", ready_a, 1'b0);
        48: begin chk_bit("ready_a", ready_a, 1'b0); chk_bit("ready_b", ready_b, 1'b1); end
        63: chk_bit("ready_a", ready_a, 1'b0);
        64: chk_bit("ready_a", ready_a, 1'b1);
        80: chk_bit("ready_a", ready_a, 1'b0);
        96: chk_bit("ready_a", ready_a, 1'b1);
        default: ;
      endcase
      if ((n + 1) % 16 == 0 && n + 1 < NCYC) begin
        push_frame(0, n + 1, a_fr[(n + 1) / 16], 4, 4, 1'b0);
        push_frame(1, n + 1, b_fr[(n + 1) / 16], 4, 4, 1'b1);
      end
      if ((n + 1) % 2 == 0 && n + 1 < NCYC) begin
        push_frame(2, n + 1, (n + 1 >= 8) ? 32'h34 : 32'h00, 2, 1, 1'b1);
      end
      cyc();
      load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    end

    vectors++;
    assert (q_a.size() + q_b.size() + q_c.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", q_a.size() + q_b.size() + q_c.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Multiplexed-display scan controller that sits directly upstream of the per-digit 7-segment decoder.
- Holds a multi-digit BCD value and time-multiplexes it onto a single shared 4-bit digit bus (num) plus a one-hot digit-enable bus.
- Handles leading-zero blanking.
- Loads new values tear-free, applying them only at frame boundaries.

Parameters:
- NDIG, 4, number of digits scanned; valid range 2..8.
- DIV, 50000, clock cycles each digit is displayed; valid range 1..2^20.
- BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures value into the staging register.
- value  in  4*NDIG  BCD digits; digit k = value[4k+3:4k]; digit 0 is least significant.
- ready  out  1  high when no staged value is waiting for commit (ready = !pending).
- num  out  4  digit code for the decoder; codes >9 pass through unchanged.
- an  out  NDIG  one-hot digit enable, active-high; bit k = digit k.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit NDIG-1 to digit 0.

Behaviour:
- Registers:
  - prescaler pc: counts 0..DIV-1.
  - digit index idx: 0..NDIG-1.
  - active: the displayed value, 4*NDIG bits.
  - staged: 4*NDIG bits.
  - pending: 1 bit.
- Reset (async, immediate): pc=0, idx=0, active=0, staged=0, pending=0.
  - Resulting outputs: num=0, an=...0001, ready=1, frame_done=0.
  - Reset asserted mid-frame or with a load pending discards the staged value.
- Tick: tick = (pc==DIV-1).
  - On tick: pc<=0, else pc<=pc+1.
  - DIV=1 gives a tick every cycle.
- Scan:
  - On tick, idx<=idx+1.
  - When idx==NDIG-1, idx wraps to 0, and that cycle is the wrap cycle.
  - frame_done is registered and goes high the cycle after the wrap cycle, for exactly one cycle.
- Load:
  - load=1 sets staged<=value and pending<=1. It is accepted regardless of ready.
  - Back-to-back loads: the last one wins.
- Commit: on a wrap cycle with pending=1, active<=staged and pending<=0.
- Simultaneous load and commit in the same cycle:
  - active takes the OLD staged value.
  - staged takes the new value.
  - pending stays 1, so the new value commits at the next wrap.
- A load while pending=0 that lands on the wrap cycle does not commit in that cycle; it commits at the next wrap.
- Outputs (combinational from registered state, zero latency from idx):
  - num = active[4*idx+3:4*idx].
  - an = one-hot(idx), unless blanked.
- Blanking (BLANK_LZ=1):
  - Let msd = the highest k with active digit k != 0, or 0 if all digits are zero.
  - For idx > msd: an = all zeros, and num still shows the digit (0).
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Non-BCD digit codes (10..15) count as nonzero. They pass through, and the decoder shows its error glyph.
- BLANK_LZ=0: an is always one-hot(idx).
- Invariant: an has at most one bit set.
- No internal width overflow: pc width is clog2(DIV) (minimum 1); idx width is clog2(NDIG).

Test Plan:
1. Reset with NDIG=4, DIV=4: assert rst mid-count -> num=0, an=0001, ready=1 immediately (asynchronously). After release, an steps 0001 (held 4 cycles) -> 0010 blanked to 0000 (all active digits are zero).
2. BLANK_LZ=0, DIV=4: load value=16'h1234, then wait for the wrap -> next frame shows num 4,3,2,1 with an 0001,0010,0100,1000, 4 cycles each. frame_done pulses once per 16 cycles.
3. Tear-free commit: load 16'h5678 mid-frame while 16'h1234 is displayed -> ready=0 until the wrap, remaining digits of the current frame still come from 1234, next frame shows 8,7,6,5, ready=1 after the commit.
4. Simultaneous load on the wrap cycle with pending=1 (staged=16'h1111, new=16'h2222) -> the frame displays 1111, pending stays 1, and 2222 appears in the following frame.
5. Blanking, BLANK_LZ=1: value=16'h0042 -> an=0001 (num 2), 0010 (num 4), 0000, 0000. value=16'h0000 -> only digit 0 enabled, num 0. value=16'h00A0 -> digit 1 shows num 10 with an=0010.
6. DIV=1, NDIG=2: idx alternates every cycle. Two loads on consecutive cycles (16'h0012 then 16'h0034, low byte) -> only 34 is committed; frame_done is high every second cycle.
